// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship game: move encodings, key bit positions and repeat FSM states.
package battleship_pkg;

  localparam logic [3:0] MOV_NONE  = 4'b0000;
  localparam logic [3:0] MOV_LEFT  = 4'b1000;
  localparam logic [3:0] MOV_UP    = 4'b0100;
  localparam logic [3:0] MOV_DOWN  = 4'b0010;
  localparam logic [3:0] MOV_RIGHT = 4'b0001;

  localparam int BTN_LEFT    = 4;
  localparam int BTN_UP      = 3;
  localparam int BTN_DOWN    = 2;
  localparam int BTN_RIGHT   = 1;
  localparam int BTN_CONFIRM = 0;
  localparam int NUM_BTNS    = 5;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  // Events arrive in mov bit order, so the winner is already a valid one-hot move code.
  function automatic logic [3:0] pick_direction(input logic [3:0] events);
    logic [3:0] winner;
    winner = MOV_NONE;
    if (events[3])      winner = MOV_LEFT;
    else if (events[2]) winner = MOV_UP;
    else if (events[1]) winner = MOV_DOWN;
    else if (events[0]) winner = MOV_RIGHT;
    return winner;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One key: synchroniser into a stability-counting debouncer, with a press (rising level) event.
module debounce_cell #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   level_d;
  logic                   synced;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_n};
    end
  end

  assign synced = ~sync[SYNC_STAGES-1];

  // The level only moves after the synced key disagrees with it for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/input_conditioner.sv
// Battleship key front end: five debounced keys, priority-arbitrated direction moves with auto-repeat.
module input_conditioner
  import battleship_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [3:0] mov,
  output logic       confirm,
  output logic [4:0] btn_level
);

  localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W   = $clog2(RCNT_MAX + 1);

  logic [NUM_BTNS-1:0] press;
  logic [3:0]          new_dir;
  logic [3:0]          dir;
  logic                dir_held;
  logic                rcnt_done;
  logic [RCNT_W-1:0]   rcnt;
  rep_state_t          state;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_key
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw_n(btn_raw[i]),
      .level(btn_level[i]),
      .press(press[i])
    );
  end

  assign new_dir   = pick_direction(press[BTN_LEFT:BTN_RIGHT]);
  assign dir_held  = |(btn_level[BTN_LEFT:BTN_RIGHT] & dir);
  assign rcnt_done = (state == DELAY) ? (rcnt == RCNT_W'(REPEAT_DELAY - 1))
                                      : (rcnt == RCNT_W'(REPEAT_RATE - 1));

  // A fresh direction press always wins; otherwise a released key beats a repeat expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dir     <= MOV_NONE;
      rcnt    <= '0;
      mov     <= MOV_NONE;
      confirm <= 1'b0;
    end else begin
      mov     <= MOV_NONE;
      confirm <= press[BTN_CONFIRM];
      case (state)
        IDLE: begin
          if (new_dir != MOV_NONE) begin
            mov   <= new_dir;
            dir   <= new_dir;
            rcnt  <= '0;
            state <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (new_dir != MOV_NONE) begin
            mov   <= new_dir;
            dir   <= new_dir;
            rcnt  <= '0;
            state <= DELAY;
          end else if (!dir_held) begin
            rcnt  <= '0;
            state <= IDLE;
          end else if (rcnt_done) begin
            mov   <= dir;
            rcnt  <= '0;
            state <= REPEAT;
          end else begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        default: begin
          rcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: logs outputs per cycle and compares against hand-derived pulse times.
module tb_input_conditioner;
  import battleship_pkg::*;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_DELAY    = 20;
  localparam int REPEAT_RATE     = 8;
  localparam int LOG_DEPTH       = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [3:0] mov;
  logic       confirm;
  logic [4:0] btn_level;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] log_mov  [0:LOG_DEPTH-1];
  logic       log_conf [0:LOG_DEPTH-1];
  logic [4:0] log_lvl  [0:LOG_DEPTH-1];
  int         log_len  = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .mov      (mov),
    .confirm  (confirm),
    .btn_level(btn_level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] raw);
    btn_raw = raw;
  endtask

  // Log index i holds the outputs after the (i+1)th rising edge since the log was cleared.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (log_len < LOG_DEPTH) begin
        log_mov[log_len]  = mov;
        log_conf[log_len] = confirm;
        log_lvl[log_len]  = btn_level;
        log_len++;
      end
    end
  endtask

  function automatic int pulsesIn(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < log_len; i++)
      if (log_mov[i] != 4'b0000) n++;
    return n;
  endfunction

  function automatic int confirmsIn(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < log_len; i++)
      if (log_conf[i]) n++;
    return n;
  endfunction

  function automatic int movCount(input logic [3:0] code);
    int n = 0;
    for (int i = 0; i < log_len; i++)
      if (log_mov[i] == code) n++;
    return n;
  endfunction

  function automatic int multiHotCount();
    int n = 0;
    for (int i = 0; i < log_len; i++)
      if ($countones(log_mov[i]) > 1) n++;
    return n;
  endfunction

  function automatic logic [4:0] levelsSeen();
    logic [4:0] acc = 5'b00000;
    for (int i = 0; i < log_len; i++)
      acc |= log_lvl[i];
    return acc;
  endfunction

  initial begin
    rst = 1'b0;
    applyStimulus(5'b00000);
    repeat (3) @(negedge clk);
    checkOutput("rst_mov", 32'(mov), 32'h0);
    checkOutput("rst_confirm", 32'(confirm), 32'h0);
    checkOutput("rst_level", 32'(btn_level), 32'h0);

    $display("[TB] reset release with all keys held");
    rst = 1'b1;
    log_len = 0;
    runCycles(10);
    checkOutput("t1_mov_e6", 32'(log_mov[5]), 32'h0);
    checkOutput("t1_level_e6", 32'(log_lvl[5]), 32'h1f);
    checkOutput("t1_mov_e7", 32'(log_mov[6]), 32'(MOV_LEFT));
    checkOutput("t1_conf_e7", 32'(log_conf[6]), 32'h1);
    checkOutput("t1_mov_count", 32'(pulsesIn(0, 9)), 32'd1);
    checkOutput("t1_conf_count", 32'(confirmsIn(0, 9)), 32'd1);
    applyStimulus(5'b11111);
    runCycles(20);

    $display("[TB] glitch filtering on up");
    log_len = 0;
    applyStimulus(5'b10111);
    runCycles(3);
    applyStimulus(5'b11111);
    runCycles(12);
    checkOutput("t2_glitch_pulses", 32'(pulsesIn(0, 14)), 32'd0);
    checkOutput("t2_glitch_level", 32'(levelsSeen()), 32'h0);
    log_len = 0;
    applyStimulus(5'b10111);
    runCycles(6);
    applyStimulus(5'b11111);
    runCycles(14);
    checkOutput("t2_level_e6", 32'(log_lvl[5]), 32'h08);
    checkOutput("t2_mov_e7", 32'(log_mov[6]), 32'(MOV_UP));
    checkOutput("t2_mov_count", 32'(pulsesIn(0, 19)), 32'd1);
    runCycles(10);

    $display("[TB] auto-repeat on right");
    log_len = 0;
    applyStimulus(5'b11101);
    runCycles(57);
    applyStimulus(5'b11111);
    runCycles(30);
    checkOutput("t3_first", 32'(log_mov[6]), 32'(MOV_RIGHT));
    checkOutput("t3_rep20", 32'(log_mov[26]), 32'(MOV_RIGHT));
    checkOutput("t3_rep28", 32'(log_mov[34]), 32'(MOV_RIGHT));
    checkOutput("t3_rep36", 32'(log_mov[42]), 32'(MOV_RIGHT));
    checkOutput("t3_rep44", 32'(log_mov[50]), 32'(MOV_RIGHT));
    checkOutput("t3_rep52", 32'(log_mov[58]), 32'(MOV_RIGHT));
    checkOutput("t3_total", 32'(pulsesIn(0, log_len - 1)), 32'd6);
    checkOutput("t3_state", 32'(dut.state), 32'(IDLE));

    $display("[TB] simultaneous left, down and confirm");
    log_len = 0;
    applyStimulus(5'b01010);
    runCycles(30);
    checkOutput("t4_mov_e7", 32'(log_mov[6]), 32'(MOV_LEFT));
    checkOutput("t4_conf_e7", 32'(log_conf[6]), 32'h1);
    checkOutput("t4_conf_count", 32'(confirmsIn(0, 29)), 32'd1);
    checkOutput("t4_mov_rep", 32'(log_mov[26]), 32'(MOV_LEFT));
    checkOutput("t4_mov_count", 32'(pulsesIn(0, 29)), 32'd2);
    checkOutput("t4_no_down", 32'(movCount(MOV_DOWN)), 32'd0);
    checkOutput("t4_multihot", 32'(multiHotCount()), 32'd0);
    applyStimulus(5'b11111);
    runCycles(20);

    $display("[TB] redirect from up to left");
    log_len = 0;
    applyStimulus(5'b10111);
    runCycles(31);
    checkOutput("t5_state_rep", 32'(dut.state), 32'(REPEAT));
    applyStimulus(5'b00111);
    runCycles(40);
    checkOutput("t5_up_first", 32'(log_mov[6]), 32'(MOV_UP));
    checkOutput("t5_up_rep", 32'(log_mov[26]), 32'(MOV_UP));
    checkOutput("t5_up_rate", 32'(log_mov[34]), 32'(MOV_UP));
    checkOutput("t5_left_press", 32'(log_mov[37]), 32'(MOV_LEFT));
    checkOutput("t5_gap", 32'(pulsesIn(38, 56)), 32'd0);
    checkOutput("t5_left_rep", 32'(log_mov[57]), 32'(MOV_LEFT));
    applyStimulus(5'b11111);
    runCycles(20);

    $display("[TB] reset during repeat");
    log_len = 0;
    applyStimulus(5'b11101);
    runCycles(27);
    checkOutput("t6_pre_mov", 32'(log_mov[26]), 32'(MOV_RIGHT));
    checkOutput("t6_pre_state", 32'(dut.state), 32'(REPEAT));
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_mov", 32'(mov), 32'h0);
    checkOutput("t6_rst_level", 32'(btn_level), 32'h0);
    checkOutput("t6_rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    log_len = 0;
    runCycles(10);
    checkOutput("t6_e6_quiet", 32'(log_mov[5]), 32'h0);
    checkOutput("t6_fresh", 32'(log_mov[6]), 32'(MOV_RIGHT));
    checkOutput("t6_count", 32'(pulsesIn(0, 9)), 32'd1);
    applyStimulus(5'b11111);
    runCycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
